line_buffer_wr_ctrl: RTL
========================

Name: line_buffer_wr_ctrl

Overview:
Parametrised write-side controller for the Sobel line buffer. It accepts a pixel stream over a valid/ready handshake and writes each whole image line into one of NUM_BANKS single-port line RAMs. Banks are used in round-robin order. The block tracks line and frame position and tells the window/read side when enough lines are buffered to form a NUM_BANKS-row kernel window. It sits between the grayscale converter and the line RAM banks.

Parameters:
DATA_WD, 8, pixel width in bits
ADDR_WD, 10, line RAM address width; must satisfy 2**ADDR_WD >= LINE_LEN
LINE_LEN, 640, pixels per line
FRAME_LINES, 480, lines per frame
NUM_BANKS, 3, number of line RAM banks (kernel height), >= 2
BANK_WD, $clog2(NUM_BANKS), bank index width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
pix_valid_i  in  1  pixel valid
pix_data_i  in  DATA_WD  pixel data
sof_i  in  1  start of frame; qualified by pix_valid_i, marks the first pixel of a frame
stall_i  in  1  read side requests backpressure
pix_ready_o  out  1  pixel accept
wdata_o  out  DATA_WD  RAM write data
waddr_o  out  ADDR_WD  RAM write address, shared by all banks
bank_we_o  out  NUM_BANKS  one-hot bank write enable
cur_bank_o  out  BANK_WD  bank currently being filled
line_done_o  out  1  one-cycle pulse, last pixel of a line written
frame_done_o  out  1  one-cycle pulse, last line of the frame written
win_ready_o  out  1  at least NUM_BANKS-1 complete lines buffered in this frame

Behaviour:
- Reset: clock is clk_i; reset is rst_ni, asynchronous, active-low. All outputs are 0. State is IDLE and all counters are 0.
- Accept: a pixel is accepted when pix_valid_i && pix_ready_o.
- Ready: pix_ready_o = 1 in IDLE; otherwise pix_ready_o = !stall_i (combinational).
- State IDLE: accepted pixels without sof_i are discarded, with no write. An accepted pixel with sof_i goes to FILL and is written as pixel 0 of line 0 in bank 0.
- State FILL: writing. Move to STREAM when the completed-line count reaches NUM_BANKS-1.
- State STREAM: writing, with win_ready_o = 1. Move to IDLE when the completed-line count reaches FRAME_LINES.
- Write latency: 1 cycle. On the cycle after an accept, wdata_o = data, waddr_o = column, and bank_we_o = 1 << bank. bank_we_o is 0 in every cycle that follows a non-accept cycle. The data and address outputs hold their last values.
- Column counter: increments per written pixel. At column LINE_LEN-1 it wraps to 0, the bank advances (NUM_BANKS-1 wraps to 0), the line count increments, and line_done_o pulses aligned with the last bank_we_o.
- frame_done_o: pulses together with the line_done_o of line FRAME_LINES-1.
- win_ready_o: drops to 0 in the same cycle the state returns to IDLE.
- sof_i during FILL or STREAM: the frame restarts. The column, bank and line count go to 0, that pixel is written at bank 0 address 0, and the state becomes FILL with win_ready_o = 0. No line_done_o is issued for the partial line.
- sof_i on the last pixel of a frame: sof takes priority. That pixel restarts the frame and frame_done_o is not pulsed.
- stall_i: freezes all counters and state, and bank_we_o is 0 on the following cycle.
- Arithmetic: all counters are unsigned and compared against the parameters by equality only, with no overflow beyond the terminal values.
- Reset mid-line: the asynchronous clear drops everything to reset values immediately. Partial RAM contents are don't-care.

Optional Feature:
Macro LB_FRAME_ERR_EN. When defined, the block adds output frame_err_o (1 bit), which is 0 at reset. It is a sticky flag, set one cycle after an accepted sof_i arrives while column != 0 or (state != IDLE and line count != 0). It clears only on reset. When the macro is undefined the port does not exist, and a mid-frame sof_i restarts the frame silently as described above.

Test Plan:
Use LINE_LEN=4, FRAME_LINES=4, NUM_BANKS=3 for all scenarios.
1. Reset, then pixels 0x10..0x13 with sof on 0x10 -> bank_we_o=001, waddr 0..3, data 0x10..0x13 one cycle after each accept. line_done_o pulses with address 3 and cur_bank_o becomes 1.
2. A full 16-pixel frame with no stall -> banks in order 0,1,2,0. win_ready_o rises after the 2nd line_done_o. frame_done_o pulses with the 4th line_done_o, then state is IDLE and win_ready_o=0.
3. 3 pixels without sof in IDLE -> pix_ready_o=1 and bank_we_o stays 000.
4. stall_i=1 for 5 cycles mid-line at column 2 -> pix_ready_o=0 and no writes. After release, the next write goes to address 2 of the same bank.
5. sof on the 3rd pixel of line 1 (bank 1) -> that pixel is written to bank 0 address 0, no line_done_o, win_ready_o=0. With LB_FRAME_ERR_EN, frame_err_o=1 from the next cycle.
6. rst_ni asserted at column 2 of line 2 -> all outputs 0 immediately. A new sof frame afterwards starts at bank 0 address 0.

Source files
------------

// File: rtl/line_buffer_wr_ctrl.sv
// ---------------------------------------------------------------------------
// line_buffer_wr_ctrl
//
// Write-side controller for the Sobel line buffer. Takes a pixel stream over
// a valid/ready handshake and writes each whole image line into one of
// NUM_BANKS single-port line RAMs, filling the banks round-robin. Tracks the
// column / line position inside the frame and flags when NUM_BANKS-1 complete
// lines are buffered, so the window side can start forming kernels.
//
// Optional feature (macro LB_FRAME_ERR_EN): adds frame_err_o, a sticky flag
// raised when a start-of-frame pixel arrives in the middle of a frame.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   pix_valid_i       pixel valid
//   pix_data_i        pixel data
//   sof_i             start of frame, qualified by pix_valid_i
//   stall_i           backpressure request from the read side
//   pix_ready_o       pixel accept (combinational)
//   wdata_o           RAM write data (holds last written value)
//   waddr_o           RAM write address shared by all banks (holds last value)
//   bank_we_o         one-hot bank write enable
//   cur_bank_o        bank currently being filled
//   line_done_o       pulse with the last write of a line
//   frame_done_o      pulse with the last write of the frame
//   win_ready_o       NUM_BANKS-1 complete lines buffered in this frame
//   frame_err_o       (LB_FRAME_ERR_EN only) sticky mid-frame sof flag
//   state_o           debug view of the FSM state (0 IDLE, 1 FILL, 2 STREAM)
//
// Handshake: a pixel transfers on a rising clk_i edge where pix_valid_i and
// pix_ready_o are both high. pix_ready_o is high in IDLE and otherwise follows
// !stall_i; it does not depend on pix_valid_i. The producer may change data
// freely while pix_ready_o is low.
// ---------------------------------------------------------------------------
module line_buffer_wr_ctrl #(
    parameter int DATA_WD     = 8,
    parameter int ADDR_WD     = 10,
    parameter int LINE_LEN    = 640,
    parameter int FRAME_LINES = 480,
    parameter int NUM_BANKS   = 3,
    parameter int BANK_WD     = $clog2(NUM_BANKS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pix_valid_i,
    input  logic [DATA_WD-1:0]   pix_data_i,
    input  logic                 sof_i,
    input  logic                 stall_i,
    output logic                 pix_ready_o,
    output logic [DATA_WD-1:0]   wdata_o,
    output logic [ADDR_WD-1:0]   waddr_o,
    output logic [NUM_BANKS-1:0] bank_we_o,
    output logic [BANK_WD-1:0]   cur_bank_o,
    output logic                 line_done_o,
    output logic                 frame_done_o,
    output logic                 win_ready_o,
`ifdef LB_FRAME_ERR_EN
    output logic                 frame_err_o,
`endif
    output logic [1:0]           state_o
);

    localparam int LC_WD = $clog2(FRAME_LINES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_WD-1:0]   col_q;
    logic [BANK_WD-1:0]   bank_q;
    logic [LC_WD-1:0]     lines_q;
    logic [DATA_WD-1:0]   wdata_q;
    logic [ADDR_WD-1:0]   waddr_q;
    logic [NUM_BANKS-1:0] bank_we_q;
    logic                 line_done_q;
    logic                 frame_done_q;
    logic                 win_ready_q;

    logic                 accept;
    logic                 wr_en;
    logic [ADDR_WD-1:0]   w_col;
    logic [BANK_WD-1:0]   w_bank;
    logic [LC_WD-1:0]     w_lines;
    logic [LC_WD-1:0]     n_lines;
    logic [BANK_WD-1:0]   n_bank;
    logic                 col_last;
    logic                 frame_end;

    // Ready is forced low while reset is asserted so every output reads 0.
    assign pix_ready_o = rst_ni && ((state_q == IDLE) || !stall_i);

    always_comb begin
        accept    = pix_valid_i && pix_ready_o;
        // In IDLE only a start-of-frame pixel is written; others are dropped.
        wr_en     = accept && (sof_i || (state_q != IDLE));
        // A sof pixel always restarts the frame, even mid-line or on the
        // last pixel of a frame, so position is taken as zero for it.
        w_col     = sof_i ? '0 : col_q;
        w_bank    = sof_i ? '0 : bank_q;
        w_lines   = sof_i ? '0 : lines_q;
        col_last  = (w_col == ADDR_WD'(LINE_LEN - 1));
        n_lines   = col_last ? (w_lines + LC_WD'(1)) : w_lines;
        frame_end = col_last && (n_lines == LC_WD'(FRAME_LINES));
        n_bank    = w_bank;
        if (col_last) begin
            n_bank = (w_bank == BANK_WD'(NUM_BANKS - 1)) ? '0 : (w_bank + BANK_WD'(1));
        end
        if (frame_end) begin
            state_d = IDLE;
        end else if ((n_lines == LC_WD'(NUM_BANKS - 1)) || ((state_q == STREAM) && !sof_i)) begin
            state_d = STREAM;
        end else begin
            state_d = FILL;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            col_q        <= '0;
            bank_q       <= '0;
            lines_q      <= '0;
            wdata_q      <= '0;
            waddr_q      <= '0;
            bank_we_q    <= '0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_ready_q  <= 1'b0;
        end else begin
            bank_we_q    <= '0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (wr_en) begin
                wdata_q      <= pix_data_i;
                waddr_q      <= w_col;
                bank_we_q    <= NUM_BANKS'(1) << w_bank;
                line_done_q  <= col_last;
                frame_done_q <= frame_end;
                col_q        <= col_last ? '0 : (w_col + ADDR_WD'(1));
                bank_q       <= n_bank;
                // Line count returns to 0 once the frame is complete.
                lines_q      <= frame_end ? '0 : n_lines;
                state_q      <= state_d;
                win_ready_q  <= (state_d == STREAM);
            end
        end
    end

`ifdef LB_FRAME_ERR_EN
    logic frame_err_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_err_q <= 1'b0;
        end else if (accept && sof_i &&
                     ((col_q != '0) || ((state_q != IDLE) && (lines_q != '0)))) begin
            frame_err_q <= 1'b1;
        end
    end
    assign frame_err_o = frame_err_q;
`endif

    assign wdata_o      = wdata_q;
    assign waddr_o      = waddr_q;
    assign bank_we_o    = bank_we_q;
    assign cur_bank_o   = bank_q;
    assign line_done_o  = line_done_q;
    assign frame_done_o = frame_done_q;
    assign win_ready_o  = win_ready_q;
    assign state_o      = state_q;

endmodule
